// File: rtl/i2c_reg_writer_pkg.sv
// Shared types and constants for the single-register I2C write engine.
package i2c_writer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP
  } state_t;

  localparam logic [1:0] QTR_0 = 2'd0;
  localparam logic [1:0] QTR_1 = 2'd1;
  localparam logic [1:0] QTR_2 = 2'd2;
  localparam logic [1:0] QTR_3 = 2'd3;

  localparam int BYTE_COUNT = 3;

  // Number of clk cycles in one quarter of an SCL period.
  function automatic int calcQuarter(input int inputClk, input int busClk);
    return inputClk / (busClk * 4);
  endfunction

endpackage

// File: rtl/i2c_reg_writer_quarter_tick.sv
// Quarter-period tick divider: one-cycle pulse every Q clk cycles.
// Holding freezes the count at its terminal value so the tick is delayed.
module i2c_quarter_tick #(
  parameter int Q = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_hold,
  output logic o_tick
);

  localparam int CW = $clog2(Q);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == CW'(Q - 1));
  assign o_tick = w_last && !i_hold;

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      r_count <= '0;
    end else if (o_tick) begin
      r_count <= '0;
    end else if (!w_last) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_reg_writer.sv
// Single-register I2C write engine: START, {chip,W}, reg, value, STOP.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL after each release.
module i2c_reg_writer
  import i2c_writer_pkg::*;
#(
  parameter int INPUT_CLK = 27_000_000,
  parameter int BUS_CLK   = 20_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] chip_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] value,
  input  logic       enable,
  output logic       done,
  output logic       ack_error,
  inout  wire        sda,
  inout  wire        scl
);

  localparam int Q = calcQuarter(INPUT_CLK, BUS_CLK);

  state_t     r_state, w_stateNext;
  logic [1:0] r_quarter, w_quarterNext;
  logic [2:0] r_bit, w_bitNext;
  logic [1:0] r_byte, w_byteNext;
  logic [7:0] r_shift, w_shiftNext;
  logic [7:0] r_regAddr, r_value;
  logic       r_ackError, w_ackErrorNext;
  logic       r_sdaMeta, r_sdaSync;
  logic       w_accept, w_tick, w_hold;
  logic       w_sdaLow, w_sclLow;

  assign w_accept = (r_state == IDLE) && enable;

  i2c_quarter_tick #(.Q(Q)) u_tick (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (w_accept),
    .i_hold  (w_hold),
    .o_tick  (w_tick)
  );

`ifdef I2C_CLK_STRETCH_EN
  logic r_sclMeta, r_sclSync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sclMeta <= 1'b1;
      r_sclSync <= 1'b1;
    end else begin
      r_sclMeta <= scl;
      r_sclSync <= r_sclMeta;
    end
  end

  // A released SCL that still reads low means the slave is stretching.
  assign w_hold = (r_state != IDLE) && !w_sclLow && !r_sclSync;
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_quarter  <= QTR_0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_shift    <= '0;
      r_regAddr  <= '0;
      r_value    <= '0;
      r_ackError <= 1'b0;
      r_sdaMeta  <= 1'b1;
      r_sdaSync  <= 1'b1;
    end else begin
      r_state    <= w_stateNext;
      r_quarter  <= w_quarterNext;
      r_bit      <= w_bitNext;
      r_byte     <= w_byteNext;
      r_shift    <= w_shiftNext;
      r_ackError <= w_ackErrorNext;
      r_sdaMeta  <= sda;
      r_sdaSync  <= r_sdaMeta;
      if (w_accept) begin
        r_regAddr <= reg_addr;
        r_value   <= value;
      end
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_quarterNext  = r_quarter;
    w_bitNext      = r_bit;
    w_byteNext     = r_byte;
    w_shiftNext    = r_shift;
    w_ackErrorNext = r_ackError;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_stateNext    = START;
          w_quarterNext  = QTR_0;
          w_bitNext      = 3'd7;
          w_byteNext     = 2'd0;
          w_shiftNext    = {chip_addr, 1'b0};
          w_ackErrorNext = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_quarter == QTR_1) begin
            w_stateNext   = BIT;
            w_quarterNext = QTR_0;
          end else begin
            w_quarterNext = r_quarter + 2'd1;
          end
        end
      end
      BIT: begin
        if (w_tick) begin
          if (r_quarter == QTR_3) begin
            w_quarterNext = QTR_0;
            if (r_bit == 3'd0) begin
              w_stateNext = ACK;
            end else begin
              w_bitNext   = r_bit - 3'd1;
              w_shiftNext = {r_shift[6:0], 1'b0};
            end
          end else begin
            w_quarterNext = r_quarter + 2'd1;
          end
        end
      end
      ACK: begin
        // A NACK on any byte abandons the rest of the write.
        if (w_tick) begin
          if (r_quarter == QTR_3) begin
            w_quarterNext = QTR_0;
            if (r_sdaSync) begin
              w_ackErrorNext = 1'b1;
              w_stateNext    = STOP;
            end else if (r_byte == 2'(BYTE_COUNT - 1)) begin
              w_stateNext = STOP;
            end else begin
              w_stateNext = BIT;
              w_bitNext   = 3'd7;
              w_byteNext  = r_byte + 2'd1;
              w_shiftNext = (r_byte == 2'd0) ? r_regAddr : r_value;
            end
          end else begin
            w_quarterNext = r_quarter + 2'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_quarter == QTR_2) begin
            w_stateNext   = IDLE;
            w_quarterNext = QTR_0;
          end else begin
            w_quarterNext = r_quarter + 2'd1;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_sdaLow = 1'b0;
    w_sclLow = 1'b0;
    case (r_state)
      START: w_sdaLow = (r_quarter == QTR_1);
      BIT: begin
        w_sclLow = (r_quarter == QTR_0) || (r_quarter == QTR_1);
        w_sdaLow = !r_shift[7];
      end
      ACK:  w_sclLow = (r_quarter == QTR_0) || (r_quarter == QTR_1);
      STOP: begin
        w_sclLow = (r_quarter == QTR_0);
        w_sdaLow = (r_quarter != QTR_2);
      end
      default: begin
        w_sdaLow = 1'b0;
        w_sclLow = 1'b0;
      end
    endcase
  end

  assign done      = (r_state == IDLE);
  assign ack_error = r_ackError;
  assign sda       = w_sdaLow ? 1'b0 : 1'bz;
  assign scl       = w_sclLow ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Self-checking bench for i2c_reg_writer with a byte-level I2C slave model.
module tb_i2c_reg_writer;

  localparam int TB_INPUT_CLK = 160_000;
  localparam int TB_BUS_CLK   = 10_000;
  localparam int Q            = TB_INPUT_CLK / (TB_BUS_CLK * 4);
  localparam logic [6:0] SLAVE_ADDR = 7'h39;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] chip_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [7:0] value = '0;
  logic       enable = 1'b0;
  logic       done;
  logic       ack_error;
  wire        sda;
  wire        scl;

  pullup (sda);
  pullup (scl);

  int nAsserts = 0;
  int nFails = 0;
  logic [7:0] expQ[$];
  bit nackValue = 1'b0;

  i2c_reg_writer #(
    .INPUT_CLK (TB_INPUT_CLK),
    .BUS_CLK   (TB_BUS_CLK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chip_addr (chip_addr),
    .reg_addr  (reg_addr),
    .value     (value),
    .enable    (enable),
    .done      (done),
    .ack_error (ack_error),
    .sda       (sda),
    .scl       (scl)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model: samples the bus once per clk, ACKs its own address and
  // checks each received byte against the scoreboard.
  logic       slaveSdaLow = 1'b0;
  logic       prevScl = 1'b1;
  logic       prevSda = 1'b1;
  logic [7:0] rxShift = '0;
  int         bitCnt = 0;
  int         byteIdx = 0;
  bit         acking = 1'b0;

  assign sda = slaveSdaLow ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    logic [31:0] expByte;
    if (prevScl && scl && prevSda && !sda) begin
      bitCnt = 0; byteIdx = 0; acking = 1'b0; slaveSdaLow = 1'b0;
    end else if (prevScl && scl && !prevSda && sda) begin
      bitCnt = 0; acking = 1'b0; slaveSdaLow = 1'b0;
    end else if (!prevScl && scl && bitCnt < 8) begin
      rxShift = {rxShift[6:0], sda};
      bitCnt++;
      if (bitCnt == 8) begin
        if (expQ.size() > 0) expByte = {24'h0, expQ.pop_front()};
        else expByte = 32'hFFFF_FFFF;
        checkOutput("rxByte", {24'h0, rxShift}, expByte);
      end
    end else if (prevScl && !scl) begin
      if (acking) begin
        slaveSdaLow = 1'b0; acking = 1'b0; bitCnt = 0; byteIdx++;
      end else if (bitCnt == 8) begin
        acking = 1'b1;
        if (byteIdx == 0) slaveSdaLow = (rxShift[7:1] == SLAVE_ADDR);
        else slaveSdaLow = !(byteIdx == 2 && nackValue);
      end
    end
    prevScl = scl;
    prevSda = sda;
  end

  task automatic applyStimulus(input logic [6:0] c, input logic [7:0] r, input logic [7:0] v,
                               input int pulseAt, input int resetAt);
    int cycles;
    int expLat;
    bit addrOk;
    logic expErr;
    addrOk = (c == SLAVE_ADDR);
    expErr = !addrOk || nackValue;
    expLat = (addrOk ? 113 : 41) * Q;
    expQ.push_back({c, 1'b0});
    if (addrOk && resetAt == 0) begin
      expQ.push_back(r);
      expQ.push_back(v);
    end
    @(negedge clk);
    chip_addr = c; reg_addr = r; value = v; enable = 1'b1;
    @(negedge clk);
    checkOutput("doneLowAfterAccept", {31'h0, done}, 32'h0);
    checkOutput("ackErrClearedOnAccept", {31'h0, ack_error}, 32'h0);
    chip_addr = 7'h00; reg_addr = ~r; value = ~v;
    @(negedge clk);
    enable = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < expLat + 50) begin
      if (pulseAt > 0 && cycles == pulseAt) begin
        chip_addr = 7'h11; reg_addr = 8'hEE; value = 8'hDD; enable = 1'b1;
      end else begin
        enable = 1'b0;
      end
      if (resetAt > 0 && cycles == resetAt) begin
        reset = 1'b0;
        @(negedge clk);
        checkOutput("resetSda", {31'h0, sda}, 32'h1);
        checkOutput("resetScl", {31'h0, scl}, 32'h1);
        checkOutput("resetDone", {31'h0, done}, 32'h1);
        checkOutput("resetAckErr", {31'h0, ack_error}, 32'h0);
        reset = 1'b1;
        return;
      end
      @(negedge clk);
      cycles++;
    end
    enable = 1'b0;
    checkOutput($sformatf("latencyInWindow(cycles=%0d,min=%0d)", cycles, expLat),
                {31'h0, (cycles >= expLat && cycles <= expLat + 2)}, 32'h1);
    checkOutput("ackError", {31'h0, ack_error}, {31'h0, expErr});
  endtask

  initial begin
    repeat (5) @(negedge clk);
    checkOutput("rstDone", {31'h0, done}, 32'h1);
    checkOutput("rstAckErr", {31'h0, ack_error}, 32'h0);
    checkOutput("rstSda", {31'h0, sda}, 32'h1);
    checkOutput("rstScl", {31'h0, scl}, 32'h1);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] ACKed write 0x39/0x41/0x10");
    applyStimulus(7'h39, 8'h41, 8'h10, 0, 0);
    $display("[TB] address NACK, chip 0x3A");
    applyStimulus(7'h3A, 8'h41, 8'h10, 0, 0);
    $display("[TB] value NACK then ACKed write");
    nackValue = 1'b1;
    applyStimulus(7'h39, 8'h22, 8'h33, 0, 0);
    nackValue = 1'b0;
    applyStimulus(7'h39, 8'h44, 8'h55, 0, 0);
    $display("[TB] enable pulsed while busy");
    applyStimulus(7'h39, 8'h5A, 8'hA5, 20 * Q, 0);
    $display("[TB] reset during register byte");
    applyStimulus(7'h39, 8'h66, 8'h77, 0, 54 * Q);
    checkOutput("abortedQueueEmpty", expQ.size(), 32'h0);
    repeat (3) @(negedge clk);
    applyStimulus(7'h39, 8'h68, 8'h79, 0, 0);

    $display("[TB] 24 back-to-back writes");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(SLAVE_ADDR, 8'h80 + 8'(i), 8'($urandom_range(0, 255)), 0, 0);
    end
    repeat (4 * Q) @(negedge clk);
    checkOutput("scoreboardDrained", expQ.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
